// File: rtl/rtype_control_unit_if.sv
// Handshake and datapath-control bundle between the R-type control unit and
// the instruction source / register-file+ALU datapath.
interface rtype_control_unit_if #(
    parameter int COUNT_WIDTH = 16
);
    logic                   instr_valid;
    logic [31:0]            instr;
    logic                   zero_flag;
    logic                   instr_ready;
    logic [4:0]             read_reg_num1;
    logic [4:0]             read_reg_num2;
    logic [4:0]             write_reg;
    logic [3:0]             alu_control;
    logic                   regwrite;
    logic                   zero_result;
    logic                   illegal_instr;
    logic [COUNT_WIDTH-1:0] retired_count;

    // Instruction source plus datapath side
    modport master (
        output instr_valid, instr, zero_flag,
        input  instr_ready, read_reg_num1, read_reg_num2, write_reg,
               alu_control, regwrite, zero_result, illegal_instr, retired_count
    );

    // Control unit side
    modport slave (
        input  instr_valid, instr, zero_flag,
        output instr_ready, read_reg_num1, read_reg_num2, write_reg,
               alu_control, regwrite, zero_result, illegal_instr, retired_count
    );
endinterface

// File: rtl/rtype_control_unit.sv
// Multi-cycle control FSM for an R-type register-file/ALU datapath.
// Accepts one instruction per valid/ready handshake, decodes it, and issues a
// single write-back strobe; also tracks the ALU zero flag and retired count.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | ready for a new instruction; last decoded fields held
// DECODE    | fields presented; illegal instructions flagged and dropped
// EXECUTE   | datapath computes; fields held stable
// WRITEBACK | regwrite strobe (unless rd==x0); zero flag and count updated
module rtype_control_unit #(
    parameter int         COUNT_WIDTH  = 16,
    parameter logic [6:0] RTYPE_OPCODE = 7'b0110011
) (
    input logic               clock,
    input logic               reset,
    rtype_control_unit_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DECODE,
        S_EXECUTE,
        S_WRITEBACK
    } state_t;

    state_t                 r_state;
    state_t                 w_next_state;
    logic [31:0]            r_instr;
    logic                   r_zero_result;
    logic [COUNT_WIDTH-1:0] r_retired_count;

    logic                   w_legal;
    logic [3:0]             w_alu_control;
    logic                   w_handshake;
    logic                   w_instr_ready;
    logic                   w_regwrite;
    logic                   w_illegal_instr;

    logic [6:0]             w_opcode;
    logic [2:0]             w_funct3;
    logic [6:0]             w_funct7;
    logic [4:0]             w_rd;

    assign w_opcode = r_instr[6:0];
    assign w_funct3 = r_instr[14:12];
    assign w_funct7 = r_instr[31:25];
    assign w_rd     = r_instr[11:7];

    // Field decode of the held instruction; anything outside the table is illegal
    always_comb begin
        w_legal       = 1'b0;
        w_alu_control = 4'b0000;
        if (w_opcode == RTYPE_OPCODE) begin
            w_legal = 1'b1;
            case ({w_funct7, w_funct3})
                {7'b0000000, 3'b000}: w_alu_control = 4'b0010;
                {7'b0100000, 3'b000}: w_alu_control = 4'b0110;
                {7'b0000000, 3'b111}: w_alu_control = 4'b0000;
                {7'b0000000, 3'b110}: w_alu_control = 4'b0001;
                {7'b0000000, 3'b100}: w_alu_control = 4'b0011;
                {7'b0000000, 3'b001}: w_alu_control = 4'b0100;
                {7'b0000000, 3'b101}: w_alu_control = 4'b0101;
                {7'b0100000, 3'b101}: w_alu_control = 4'b0111;
                {7'b0000000, 3'b010}: w_alu_control = 4'b1000;
                {7'b0000000, 3'b011}: w_alu_control = 4'b1001;
                default: begin
                    w_legal       = 1'b0;
                    w_alu_control = 4'b0000;
                end
            endcase
        end
    end

    assign w_handshake = bus.instr_valid && w_instr_ready;

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and per-state strobes
    always_comb begin
        w_next_state    = r_state;
        w_instr_ready   = 1'b0;
        w_regwrite      = 1'b0;
        w_illegal_instr = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_instr_ready = 1'b1;
                if (bus.instr_valid) begin
                    w_next_state = S_DECODE;
                end
            end
            S_DECODE: begin
                if (w_legal) begin
                    w_next_state = S_EXECUTE;
                end else begin
                    w_illegal_instr = 1'b1;
                    w_next_state    = S_IDLE;
                end
            end
            S_EXECUTE: begin
                w_next_state = S_WRITEBACK;
            end
            S_WRITEBACK: begin
                w_regwrite   = (w_rd != 5'd0);
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // Instruction register; its fields drive the datapath until the next accept
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_instr <= 32'd0;
        end else if (w_handshake) begin
            r_instr <= bus.instr;
        end
    end

    // Retirement bookkeeping at the end of write-back (x0 writes still retire)
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_zero_result   <= 1'b0;
            r_retired_count <= '0;
        end else if (r_state == S_WRITEBACK) begin
            r_zero_result   <= bus.zero_flag;
            r_retired_count <= r_retired_count + COUNT_WIDTH'(1);
        end
    end

    assign bus.instr_ready   = w_instr_ready;
    assign bus.read_reg_num1 = r_instr[19:15];
    assign bus.read_reg_num2 = r_instr[24:20];
    assign bus.write_reg     = w_rd;
    assign bus.alu_control   = w_alu_control;
    assign bus.regwrite      = w_regwrite;
    assign bus.zero_result   = r_zero_result;
    assign bus.illegal_instr = w_illegal_instr;
    assign bus.retired_count = r_retired_count;

endmodule

// File: tb/tb_rtype_control_unit.sv
// Bench for rtype_control_unit: directed steps plus randomized instructions,
// checked against a table-driven reference of the instruction set.
module tb_rtype_control_unit;

    localparam int CW = 4;

    logic clock;
    logic reset;

    rtype_control_unit_if #(.COUNT_WIDTH(CW)) bus ();

    rtype_control_unit #(.COUNT_WIDTH(CW)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [CW-1:0] exp_count;
    logic          exp_zero;

    logic [6:0] tbl_f7  [10];
    logic [2:0] tbl_f3  [10];
    logic [3:0] tbl_alu [10];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference decode: look the (funct7,funct3) pair up in the instruction table
    task automatic ref_decode(input logic [31:0] w, output logic legal, output logic [3:0] alu);
        legal = 1'b0;
        alu   = 4'b0000;
        if (w[6:0] == 7'b0110011) begin
            for (int k = 0; k < 10; k++) begin
                if (w[31:25] == tbl_f7[k] && w[14:12] == tbl_f3[k]) begin
                    legal = 1'b1;
                    alu   = tbl_alu[k];
                end
            end
        end
    endtask

    // Present one instruction starting just after a falling edge in IDLE and
    // follow it to the cycle after it completes.
    task automatic run_instr(input logic [31:0] ins, input logic zf, input bit hold);
        logic       legal;
        logic [3:0] alu;
        ref_decode(ins, legal, alu);
        bus.instr_valid = 1'b1;
        bus.instr       = ins;
        bus.zero_flag   = zf;
        check("ready_idle", bus.instr_ready, 1'b1);
        @(posedge clock);
        @(negedge clock);
        if (!hold) bus.instr_valid = 1'b0;
        check("ready_decode", bus.instr_ready, 1'b0);
        check("illegal_decode", bus.illegal_instr, !legal);
        check("regwrite_decode", bus.regwrite, 1'b0);
        if (!legal) begin
            @(negedge clock);
            check("illegal_after", bus.illegal_instr, 1'b0);
            check("ready_after_illegal", bus.instr_ready, 1'b1);
            check("regwrite_after_illegal", bus.regwrite, 1'b0);
            check("count_illegal", bus.retired_count, exp_count);
            check("zero_illegal", bus.zero_result, exp_zero);
            return;
        end
        check("rs1_decode", bus.read_reg_num1, ins[19:15]);
        check("rs2_decode", bus.read_reg_num2, ins[24:20]);
        check("rd_decode", bus.write_reg, ins[11:7]);
        check("alu_decode", bus.alu_control, alu);
        @(negedge clock);
        check("ready_execute", bus.instr_ready, 1'b0);
        check("regwrite_execute", bus.regwrite, 1'b0);
        check("alu_execute", bus.alu_control, alu);
        check("rs1_execute", bus.read_reg_num1, ins[19:15]);
        @(negedge clock);
        check("ready_wb", bus.instr_ready, 1'b0);
        check("regwrite_wb", bus.regwrite, ins[11:7] != 5'd0);
        check("rd_wb", bus.write_reg, ins[11:7]);
        check("alu_wb", bus.alu_control, alu);
        exp_count = exp_count + 1'b1;
        exp_zero  = zf;
        @(negedge clock);
        check("ready_back_idle", bus.instr_ready, 1'b1);
        check("regwrite_back_idle", bus.regwrite, 1'b0);
        check("zero_result", bus.zero_result, exp_zero);
        check("retired_count", bus.retired_count, exp_count);
        check("alu_hold_idle", bus.alu_control, alu);
        check("rs2_hold_idle", bus.read_reg_num2, ins[24:20]);
    endtask

    function automatic logic [31:0] rand_legal();
        int idx;
        logic [4:0] rs1, rs2, rd;
        idx = $urandom_range(0, 9);
        rs1 = 5'($urandom);
        rs2 = 5'($urandom);
        rd  = 5'($urandom_range(0, 31));
        return {tbl_f7[idx], rs2, rs1, tbl_f3[idx], rd, 7'b0110011};
    endfunction

    initial begin
        tbl_f7[0] = 7'b0000000; tbl_f3[0] = 3'b000; tbl_alu[0] = 4'b0010;
        tbl_f7[1] = 7'b0100000; tbl_f3[1] = 3'b000; tbl_alu[1] = 4'b0110;
        tbl_f7[2] = 7'b0000000; tbl_f3[2] = 3'b111; tbl_alu[2] = 4'b0000;
        tbl_f7[3] = 7'b0000000; tbl_f3[3] = 3'b110; tbl_alu[3] = 4'b0001;
        tbl_f7[4] = 7'b0000000; tbl_f3[4] = 3'b100; tbl_alu[4] = 4'b0011;
        tbl_f7[5] = 7'b0000000; tbl_f3[5] = 3'b001; tbl_alu[5] = 4'b0100;
        tbl_f7[6] = 7'b0000000; tbl_f3[6] = 3'b101; tbl_alu[6] = 4'b0101;
        tbl_f7[7] = 7'b0100000; tbl_f3[7] = 3'b101; tbl_alu[7] = 4'b0111;
        tbl_f7[8] = 7'b0000000; tbl_f3[8] = 3'b010; tbl_alu[8] = 4'b1000;
        tbl_f7[9] = 7'b0000000; tbl_f3[9] = 3'b011; tbl_alu[9] = 4'b1001;

        exp_count       = '0;
        exp_zero        = 1'b0;
        reset           = 1'b1;
        bus.instr_valid = 1'b0;
        bus.instr       = 32'd0;
        bus.zero_flag   = 1'b0;

        // Reset values
        #3;
        check("rst_ready", bus.instr_ready, 1'b1);
        check("rst_regwrite", bus.regwrite, 1'b0);
        check("rst_illegal", bus.illegal_instr, 1'b0);
        check("rst_rs1", bus.read_reg_num1, 5'd0);
        check("rst_rs2", bus.read_reg_num2, 5'd0);
        check("rst_rd", bus.write_reg, 5'd0);
        check("rst_alu", bus.alu_control, 4'b0000);
        check("rst_zero", bus.zero_result, 1'b0);
        check("rst_count", bus.retired_count, 0);
        @(negedge clock);
        reset = 1'b0;

        // Valid held off: nothing should start
        @(negedge clock);
        check("idle_no_valid", bus.instr_ready, 1'b1);

        run_instr(32'h002081B3, 1'b0, 1'b0);   // ADD x3,x1,x2
        run_instr(32'h405282B3, 1'b1, 1'b0);   // SUB x5,x5,x5, zero
        run_instr(32'h0020F1B3, 1'b0, 1'b0);   // AND x3,x1,x2, non-zero
        run_instr(32'h00208033, 1'b1, 1'b0);   // ADD x0,x1,x2

        // Reset in the middle of EXECUTE discards the instruction
        bus.instr_valid = 1'b1;
        bus.instr       = 32'h002081B3;
        @(posedge clock);
        @(negedge clock);
        bus.instr_valid = 1'b0;
        @(negedge clock);
        #1 reset = 1'b1;
        #1;
        exp_count = '0;
        exp_zero  = 1'b0;
        check("midrst_regwrite", bus.regwrite, 1'b0);
        check("midrst_ready", bus.instr_ready, 1'b1);
        check("midrst_count", bus.retired_count, exp_count);
        @(negedge clock);
        reset = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clock);
            check("midrst_no_wb", bus.regwrite, 1'b0);
            check("midrst_no_illegal", bus.illegal_instr, 1'b0);
        end
        check("midrst_count_after", bus.retired_count, exp_count);

        // Illegal encodings
        run_instr(32'h00108093, 1'b0, 1'b0);   // ADDI
        run_instr(32'h4020F1B3, 1'b0, 1'b0);   // funct7 0100000, funct3 111

        // Back-to-back with valid held high
        run_instr(32'h002081B3, 1'b1, 1'b1);
        run_instr(32'h405282B3, 1'b0, 1'b1);
        run_instr(32'h0020E233, 1'b1, 1'b1);
        bus.instr_valid = 1'b0;

        // Random legal traffic up to 17 retirements since the reset
        for (int n = 0; n < 14; n++) begin
            run_instr(rand_legal(), 1'($urandom), 1'($urandom_range(0, 1)));
            bus.instr_valid = 1'b0;
        end
        check("count_wrap_17", bus.retired_count, 1);

        // Random raw words, judged by the reference decode
        for (int n = 0; n < 8; n++) begin
            run_instr($urandom, 1'($urandom), 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/rtype_control_unit.md
Name: rtype_control_unit

Overview:
Multi-cycle control FSM that drives the register-file/ALU datapath, the consumer of the datapath's control inputs. It accepts one 32-bit RV32I instruction per valid/ready handshake, decodes R-type fields into register numbers and the 4-bit ALU code, and sequences a single write-back strobe. It also latches the datapath's zero_flag and counts retired instructions.

Parameters:
COUNT_WIDTH, 16, width of retired-instruction counter (wraps).
RTYPE_OPCODE, 7'b0110011, only opcode accepted as legal.

Ports:
clock  input  1  system clock, all state updates on rising edge
reset  input  1  asynchronous, active-high; forces all state/outputs to reset values immediately
instr_valid  input  1  instruction present on instr
instr  input  32  RV32I instruction word
zero_flag  input  1  ALU zero result from datapath
instr_ready  output  1  unit can accept an instruction
read_reg_num1  output  5  rs1 to datapath
read_reg_num2  output  5  rs2 to datapath
write_reg  output  5  rd to datapath
alu_control  output  4  ALU operation code
regwrite  output  1  register-file write enable, single-cycle pulse
zero_result  output  1  zero_flag captured at write-back of last legal instruction
illegal_instr  output  1  single-cycle pulse on rejected instruction
retired_count  output  COUNT_WIDTH  number of legal instructions written back

Behaviour:
- Reset values: state IDLE, instr_ready 1, all reg-number outputs 0, alu_control 4'b0000, regwrite 0, zero_result 0, illegal_instr 0, retired_count 0, instruction register 0.
- States: IDLE -> DECODE -> EXECUTE -> WRITEBACK -> IDLE; DECODE -> IDLE on illegal.
- IDLE: instr_ready=1. On instr_valid && instr_ready at a clock edge, capture instr, go DECODE. instr_valid without handshake: no effect. instr_ready=0 in every other state.
- DECODE (1 cycle): read_reg_num1=instr[19:15], read_reg_num2=instr[24:20], write_reg=instr[11:7], alu_control from funct7/funct3. Illegal if opcode != RTYPE_OPCODE or funct7/funct3 combination not in table; then illegal_instr pulses high for exactly the DECODE cycle, regwrite stays 0, counter unchanged, next state IDLE.
- ALU code table (funct7,funct3 -> alu_control): 0000000,000 ADD -> 0010; 0100000,000 SUB -> 0110; 0000000,111 AND -> 0000; 0000000,110 OR -> 0001; 0000000,100 XOR -> 0011; 0000000,001 SLL -> 0100; 0000000,101 SRL -> 0101; 0100000,101 SRA -> 0111; 0000000,010 SLT -> 1000; 0000000,011 SLTU -> 1001. All others illegal.
- EXECUTE (1 cycle): register numbers and alu_control held stable; regwrite 0.
- WRITEBACK (1 cycle): fields still held; regwrite=1 iff rd != 0 (x0 write suppressed, instruction still retires); at end of cycle zero_result <= zero_flag, retired_count <= retired_count+1 (mod 2^COUNT_WIDTH); next IDLE.
- Outputs read_reg_num1/2, write_reg, alu_control hold last decoded values through IDLE until next DECODE.
- Latency: handshake edge to regwrite high = 3 cycles (DECODE, EXECUTE, then WRITEBACK). Throughput: one instruction per 4 cycles; next handshake possible on the edge ending WRITEBACK+IDLE cycle.
- Reset mid-operation: asynchronous; regwrite and illegal_instr drop immediately, in-flight instruction discarded, not counted.
- Counter wrap: all-ones + 1 -> 0, no flag.

Test Plan:
- Reset: assert reset mid-EXECUTE -> regwrite 0, instr_ready 1, retired_count 0 immediately, no write-back afterwards.
- ADD x3,x1,x2 (0x002081B3) with valid -> DECODE rs1=1, rs2=2, rd=3, alu_control 0010; regwrite high exactly one cycle, 3 cycles after handshake; retired_count 1.
- SUB x5,x5,x5 (0x405282B3), bench drives zero_flag=1 -> alu_control 0110, zero_result 1 after WRITEBACK; then AND with zero_flag=0 -> zero_result 0.
- ADD x0,x1,x2 (0x00208033) -> regwrite never asserts, retired_count increments.
- Illegal: opcode 0010011 (ADDI 0x00108093) and funct7 0100000 with funct3 111 -> illegal_instr one-cycle pulse, no regwrite, count unchanged, instr_ready 1 next cycle.
- Back-to-back: instr_valid held high with 3 instructions -> accepted every 4 cycles, instr_ready low during DECODE/EXECUTE/WRITEBACK; COUNT_WIDTH=4 with 17 instructions -> retired_count 1.
